// File: rtl/tsc_pkg.sv
// Shared constants, address-field helpers and FSM state type for the instruction cache.
package tsc_pkg;

    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned OFFSET_W   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StMissReq,
        StMissWait
    } state_e;

    function automatic int unsigned index_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned lines);
        return ADDR_W - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_tag_ram.sv
// Tag and valid storage: asynchronous read, synchronous write, single-cycle bulk valid clear.
module icache_tag_ram #(
    parameter int unsigned LINES = 8,
    parameter int unsigned TAG_W = 11,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clear_all
);

    logic [TAG_W-1:0] tag_mem [LINES];
    logic [LINES-1:0] valid_q;

    // Clear beats a coincident write so a flush always leaves the line invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with single-line refill from a 64-bit line memory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache #(
    parameter int unsigned LINES     = 8,
    parameter int unsigned WORD_SIZE = tsc_pkg::WORD_SIZE
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       cpu_req,
    input  logic [15:0]                                cpu_addr,
    output logic [WORD_SIZE-1:0]                       cpu_data,
    output logic                                       cpu_ready,
    output logic                                       i_readM,
    output logic [15:0]                                i_address,
    input  logic [tsc_pkg::LINE_WORDS*WORD_SIZE-1:0]   i_data,
    input  logic                                       i_readyM,
    input  logic                                       i_input_readyM,
    input  logic                                       flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                                hit_count,
    output logic [15:0]                                miss_count
`endif
);
    import tsc_pkg::*;

    localparam int unsigned IDX_W  = index_width(LINES);
    localparam int unsigned TAG_W  = tag_width(LINES);
    localparam int unsigned LINE_W = LINE_WORDS * WORD_SIZE;

    state_e            state_q, state_d;
    logic [15:2]       miss_line_q, miss_line_d;
    logic              drop_q, drop_d;
    logic [LINE_W-1:0] data_ram [LINES];
    logic [LINE_W-1:0] rd_line;

    logic [1:0]        cpu_offset;
    logic [IDX_W-1:0]  cpu_index, fill_index;
    logic [TAG_W-1:0]  cpu_tag, fill_tag, rd_tag;
    logic              rd_valid, lookup_hit;
    logic              hit, miss_start, fill_en, fill_write;

    assign cpu_offset = cpu_addr[1:0];
    assign cpu_index  = cpu_addr[IDX_W+1:2];
    assign cpu_tag    = cpu_addr[15:IDX_W+2];
    assign fill_index = miss_line_q[IDX_W+1:2];
    assign fill_tag   = miss_line_q[15:IDX_W+2];
    assign lookup_hit = rd_valid && (rd_tag == cpu_tag);
    assign rd_line    = data_ram[cpu_index];
    // A flush on the fill edge, or one seen earlier in the miss, discards the line.
    assign fill_write = fill_en && !drop_q && !flush;

    icache_tag_ram #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tag_ram (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (cpu_index),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (fill_write),
        .wr_index  (fill_index),
        .wr_tag    (fill_tag),
        .clear_all (flush)
    );

    always_ff @(posedge clk) begin
        if (fill_write) begin
            data_ram[fill_index] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            miss_line_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_line_d = miss_line_q;
        drop_d      = drop_q;
        hit         = 1'b0;
        miss_start  = 1'b0;
        fill_en     = 1'b0;
        i_readM     = 1'b0;
        i_address   = '0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req && !flush) begin
                    if (lookup_hit) begin
                        hit = 1'b1;
                    end else begin
                        miss_start  = 1'b1;
                        miss_line_d = cpu_addr[15:2];
                        state_d     = StMissReq;
                    end
                end
            end
            StMissReq: begin
                i_readM   = 1'b1;
                i_address = {miss_line_q, 2'b00};
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (i_readyM) begin
                    state_d = StMissWait;
                end
            end
            StMissWait: begin
                if (i_input_readyM) begin
                    fill_en = 1'b1;
                    drop_d  = 1'b0;
                    state_d = StIdle;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cpu_ready = hit;
    assign cpu_data  = hit ? rd_line[cpu_offset*WORD_SIZE +: WORD_SIZE] : '0;

`ifdef ICACHE_STATS_EN
    logic fill_done_q;
    logic count_hit;

    // The re-lookup right after a refill completes its own miss; it is not a separate hit.
    assign count_hit = hit && !(fill_done_q && (cpu_addr[15:2] == miss_line_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count   <= '0;
            miss_count  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= fill_en;
            if (count_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: line-level cache model plus directed fetch scenarios.
module tb_icache;

    localparam int LINES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        i_readM;
    logic [15:0] i_address;
    logic [63:0] i_data;
    logic        i_readyM;
    logic        i_input_readyM;
    logic        flush;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    icache #(
        .LINES     (LINES),
        .WORD_SIZE (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_data       (cpu_data),
        .cpu_ready      (cpu_ready),
        .i_readM        (i_readM),
        .i_address      (i_address),
        .i_data         (i_data),
        .i_readyM       (i_readyM),
        .i_input_readyM (i_input_readyM),
        .flush          (flush)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int reads = 0;
    logic [15:0] last_read_addr = '0;
    logic [15:0] mem [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: one request at a time, accepted at edge E0, line returned for edge E5.
    initial begin
        logic [9:0] a;
        forever begin
            @(negedge clk);
            if (!reset && i_readM && i_readyM) begin
                a = i_address[9:0];
                reads++;
                last_read_addr = i_address;
                @(posedge clk);
                #1 i_readyM = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                i_input_readyM = 1'b1;
                i_data = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
                @(posedge clk);
                #1;
                i_input_readyM = 1'b0;
                i_data = '0;
                i_readyM = 1'b1;
            end
        end
    end

    // Model: which line address each set holds, and one outstanding refill.
    bit          mvalid [64];
    logic [13:0] mline  [64];
    bit          pend, acc, drop, just_done;
    logic [15:0] paddr;
    int          exp_hits, exp_misses;

    always @(negedge clk) begin
        int          idx, pidx;
        logic [13:0] line;
        bit          hit_e, e_rm;
        logic [15:0] e_data, e_addr;
        if (reset) begin
            for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
            pend = 0; acc = 0; drop = 0; just_done = 0;
            exp_hits = 0; exp_misses = 0;
            chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
            chk("rst_cpu_data", 32'(cpu_data), 32'd0);
            chk("rst_i_readM", 32'(i_readM), 32'd0);
            chk("rst_i_address", 32'(i_address), 32'd0);
`ifdef ICACHE_STATS_EN
            chk("rst_hit_count", 32'(hit_count), 32'd0);
            chk("rst_miss_count", 32'(miss_count), 32'd0);
`endif
        end else begin
            line  = cpu_addr[15:2];
            idx   = int'(line) % LINES;
            hit_e = !pend && cpu_req && !flush && mvalid[idx] && (mline[idx] == line);
            e_data = hit_e ? mem[cpu_addr[9:0]] : 16'h0000;
            e_rm   = pend && !acc;
            e_addr = e_rm ? {paddr[15:2], 2'b00} : 16'h0000;
            chk("cpu_ready", 32'(cpu_ready), 32'(hit_e));
            chk("cpu_data", 32'(cpu_data), 32'(e_data));
            chk("i_readM", 32'(i_readM), 32'(e_rm));
            chk("i_address", 32'(i_address), 32'(e_addr));
`ifdef ICACHE_STATS_EN
            chk("hit_count", 32'(hit_count), 32'(exp_hits));
            chk("miss_count", 32'(miss_count), 32'(exp_misses));
`endif
            if (hit_e && !(just_done && line == paddr[15:2]) && exp_hits < 65535) exp_hits++;
            just_done = 0;
            if (flush) begin
                for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
                if (pend) drop = 1;
            end
            if (!pend) begin
                if (cpu_req && !hit_e && !flush) begin
                    pend = 1; acc = 0; drop = 0; paddr = cpu_addr;
                    if (exp_misses < 65535) exp_misses++;
                end
            end else if (!acc) begin
                if (i_readyM) acc = 1;
            end else if (i_input_readyM) begin
                pidx = int'(paddr[15:2]) % LINES;
                if (!drop && !flush) begin
                    mvalid[pidx] = 1'b1;
                    mline[pidx]  = paddr[15:2];
                end
                pend = 0; drop = 0; just_done = 1;
            end
        end
    end

    task automatic fetch(input logic [15:0] a, output logic [15:0] d, output int n);
        bit got;
        got = 0;
        n = 0;
        d = '0;
        cpu_req = 1'b1;
        cpu_addr = a;
        while (!got && n <= 60) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1;
                d = cpu_data;
            end else begin
                n++;
            end
        end
        if (!got) chk("fetch_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    task automatic wait_read(input int r0);
        int k;
        k = 0;
        while (reads == r0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (reads == r0) chk("read_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        int n, r0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 16'h0137) ^ 16'h5A5A;
        mem[0] = 16'h9023; mem[1] = 16'h0001; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        i_readyM = 1'b1; i_input_readyM = 1'b0; i_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Cold miss on 0x0000
        fetch(16'h0000, d, n);
        chk("cold_data", 32'(d), 32'h9023);
        chk("cold_latency", 32'(n), 32'd7);
        chk("cold_reads", 32'(reads), 32'd1);
        chk("cold_read_addr", 32'(last_read_addr), 32'h0000);

        // Same-line hits
        fetch(16'h0001, d, n);
        chk("hit1_data", 32'(d), 32'h0001);
        chk("hit1_latency", 32'(n), 32'd0);
        fetch(16'h0002, d, n);
        chk("hit2_data", 32'(d), 32'hFFFF);
        chk("hit2_latency", 32'(n), 32'd0);
        chk("hits_no_read", 32'(reads), 32'd1);
`ifdef ICACHE_STATS_EN
        chk("stats_hits", 32'(hit_count), 32'd2);
        chk("stats_misses", 32'(miss_count), 32'd1);
`endif

        // Index-0 conflict between 0x0020 and 0x0000
        fetch(16'h0020, d, n);
        chk("conf_a_data", 32'(d), 32'(mem[16'h20]));
        chk("conf_a_latency", 32'(n), 32'd7);
        chk("conf_a_addr", 32'(last_read_addr), 32'h0020);
        fetch(16'h0000, d, n);
        chk("conf_b_data", 32'(d), 32'h9023);
        chk("conf_b_latency", 32'(n), 32'd7);
        chk("conf_reads", 32'(reads), 32'd3);

        // Flush in idle suppresses a would-be hit, then the line misses
        cpu_req = 1'b1; cpu_addr = 16'h0003; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_ready", 32'(cpu_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        fetch(16'h0003, d, n);
        chk("post_flush_data", 32'(d), 32'h0000);
        chk("post_flush_latency", 32'(n), 32'd7);
        chk("post_flush_reads", 32'(reads), 32'd4);

        // Flush during refill wait discards the line; held request misses again
        r0 = reads;
        fork
            fetch(16'h0041, d, n);
            begin
                wait_read(r0);
                @(posedge clk);
                @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        chk("drop_data", 32'(d), 32'(mem[16'h41]));
        chk("drop_latency", 32'(n), 32'd14);
        chk("drop_reads", 32'(reads - r0), 32'd2);

        // Reset two cycles after the request is accepted; late line is ignored
        r0 = reads;
        cpu_req = 1'b1; cpu_addr = 16'h0082;
        wait_read(r0);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 20 && !i_readyM; k++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_mem_idle", 32'(i_readyM), 32'd1);
        fetch(16'h0082, d, n);
        chk("rst_refetch_data", 32'(d), 32'(mem[16'h82]));
        chk("rst_refetch_latency", 32'(n), 32'd7);
        chk("rst_reads", 32'(reads - r0), 32'd2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
